btn_led_ctrl: RTL

Multi-channel successor to the single push-button/LED passthrough. Per channel:
- synchronises and debounces a raw button input;
- produces a single-cycle press pulse;
- each press advances that channel's LED mode through OFF -> ON -> BLINK -> FOLLOW -> OFF.

Sits directly between board buttons and LEDs. All blinking channels share one prescaler, so they blink in phase.

---
 rtl/btn_led_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/btn_led_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/btn_led_pkg.sv
// Shared types and helpers for the button/LED controller.
package btn_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FOLLOW = 2'd3
  } led_mode_e;

  // Press order: OFF -> ON -> BLINK -> FOLLOW -> OFF.
  function automatic led_mode_e next_mode(input led_mode_e m);
    led_mode_e n;
    n = MODE_OFF;
    case (m)
      MODE_OFF:    n = MODE_ON;
      MODE_ON:     n = MODE_BLINK;
      MODE_BLINK:  n = MODE_FOLLOW;
      MODE_FOLLOW: n = MODE_OFF;
      default:     n = MODE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One channel: 2-flop synchroniser, stable-count debouncer, rising-edge pulse.
module btn_debounce
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_db_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl, differ, accept;

  assign lvl    = sync_q[1];
  assign differ = lvl ^ btn_db_o;
  assign accept = differ && (cnt_q == CNT_MAX);

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

  // Count consecutive cycles the synced level disagrees; accept after a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      btn_db_o <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      press_o <= accept & lvl;
      if (!differ) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q    <= '0;
        btn_db_o <= lvl;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_led_ctrl.sv
// Multi-channel button debouncer with per-channel LED mode cycling and shared blink.
module btn_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_HALF      = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     btn_i,
  input  logic                  clear_i,
  output logic [NUM_CH-1:0]     btn_db_o,
  output logic [NUM_CH-1:0]     press_o,
  output logic [2*NUM_CH-1:0]   mode_o,
  output logic [NUM_CH-1:0]     led_o
);

  localparam int PW = $clog2(BLINK_HALF);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_HALF - 1);

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic [PW-1:0] presc_q;
  logic          blink_phase_q;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Free-running prescaler; every blinking channel shares this phase.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q       <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_mode_e mode_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst_n    (rst_int_n),
      .btn_i    (btn_i[g]),
      .btn_db_o (btn_db_o[g]),
      .press_o  (press_o[g])
    );

    // Advance mode on a press; clear wins over a coincident press.
    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)    mode_q <= MODE_OFF;
      else if (clear_i)  mode_q <= MODE_OFF;
      else if (press_o[g]) mode_q <= next_mode(mode_q);
    end

    assign mode_o[2*g +: 2] = mode_q;

    // Registered LED drive selected by the current mode.
    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        led_o[g] <= 1'b0;
      end else begin
        case (mode_q)
          MODE_OFF:    led_o[g] <= 1'b0;
          MODE_ON:     led_o[g] <= 1'b1;
          MODE_BLINK:  led_o[g] <= blink_phase_q;
          MODE_FOLLOW: led_o[g] <= btn_db_o[g];
          default:     led_o[g] <= 1'b0;
        endcase
      end
    end
  end

endmodule
